// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_pkg
//  Description : Shared types and constants for the ASCII-hex UART frame
//                parser: parser state encoding, error codes and the ASCII
//                characters the parser treats specially.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_frame_pkg;

    // Parser state; 3 bits cover the five states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CNT  = 3'd1,
        ST_CMD  = 3'd2,
        ST_ADDR = 3'd3,
        ST_DATA = 3'd4
    } state_t;

    // err_code values
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHAR = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Frame start character and line terminators. CR/LF need no special
    // handling: they are silently dropped in IDLE like any other non-'L'
    // byte, and are bad characters inside a frame.
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage : uart_frame_pkg
`default_nettype wire

// File: rtl/uart_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : uart_hex_decode
//  Description : Combinational ASCII-hex to nibble decoder, case-insensitive.
//  Ports       : byte_in [7:0] - ASCII character
//                nibble  [3:0] - decoded value (0 when not hex)
//                is_hex        - byte_in is one of 0-9, A-F, a-f
//  Revision    : 1.0  initial release
// ============================================================================
module uart_hex_decode (
    input  logic [7:0] byte_in,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            nibble = byte_in[3:0];
            is_hex = 1'b1;
        end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                     (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
            nibble = byte_in[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule : uart_hex_decode
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser
//  Description : Parses an ASCII-hex byte stream of the form
//                'L' <count> <command> <address> <data x (count+1)>
//                into a header (command/address/count) and a burst of data
//                words presented on a valid/ready interface. Reports bad
//                characters and data overflow; 'L' anywhere restarts a frame.
//  Ports       : clk, rst (asynchronous, active low)
//                byte_available/byte_in       - input byte strobe + byte
//                hdr_valid, out_command/address/count - header outputs
//                data_valid/out_data/data_ready - data word handshake
//                busy                         - parser not idle
//                err_pulse/err_code           - error strobe and held code
//  Options     : `define UART_FRAME_PARSER_TIMEOUT_EN enables an inter-byte
//                timeout of TIMEOUT_CYC clocks (err_code 3).
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int CMD_W       = 32,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_available,
    input  logic [7:0]        byte_in,
    output logic              hdr_valid,
    output logic [CMD_W-1:0]  out_command,
    output logic [ADDR_W-1:0] out_address,
    output logic [CNT_W-1:0]  out_count,
    output logic              data_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              data_ready,
    output logic              busy,
    output logic              err_pulse,
    output logic [1:0]        err_code
);

    // Nibble counter must index the longest field.
    localparam int MAX_A   = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
    localparam int MAX_B   = (DATA_W > CNT_W) ? DATA_W : CNT_W;
    localparam int MAX_NIB = ((MAX_A > MAX_B) ? MAX_A : MAX_B) / 4;
    localparam int NIB_W   = $clog2(MAX_NIB + 1);

    localparam logic [NIB_W-1:0] CNT_LAST  = NIB_W'(CNT_W / 4 - 1);
    localparam logic [NIB_W-1:0] CMD_LAST  = NIB_W'(CMD_W / 4 - 1);
    localparam logic [NIB_W-1:0] ADDR_LAST = NIB_W'(ADDR_W / 4 - 1);
    localparam logic [NIB_W-1:0] DATA_LAST = NIB_W'(DATA_W / 4 - 1);

    // ------------------------------------------------------------------
    // Hex decode
    // ------------------------------------------------------------------
    logic [3:0] nib;
    logic       is_hex;

    uart_hex_decode u_hex_decode (
        .byte_in (byte_in),
        .nibble  (nib),
        .is_hex  (is_hex)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,       state_d;
    logic [NIB_W-1:0]    nib_cnt_q,     nib_cnt_d;
    logic [CNT_W-1:0]    cnt_fld_q,     cnt_fld_d;
    logic [CMD_W-1:0]    cmd_fld_q,     cmd_fld_d;
    logic [ADDR_W-1:0]   addr_fld_q,    addr_fld_d;
    logic [DATA_W-1:0]   data_fld_q,    data_fld_d;
    logic [CNT_W-1:0]    words_left_q,  words_left_d;

    logic                hdr_valid_q,   hdr_valid_d;
    logic [CMD_W-1:0]    out_command_q, out_command_d;
    logic [ADDR_W-1:0]   out_address_q, out_address_d;
    logic [CNT_W-1:0]    out_count_q,   out_count_d;
    logic                data_valid_q,  data_valid_d;
    logic [DATA_W-1:0]   out_data_q,    out_data_d;
    logic                err_pulse_q,   err_pulse_d;
    logic [1:0]          err_code_q,    err_code_d;

    // Shifted field values with the incoming nibble appended at the LSB
    // end; the cast drops the oldest nibble, which also works for 4-bit
    // fields where an explicit [W-5:0] slice would not exist.
    logic [CNT_W-1:0]    cnt_shift;
    logic [CMD_W-1:0]    cmd_shift;
    logic [ADDR_W-1:0]   addr_shift;
    logic [DATA_W-1:0]   data_shift;

    assign cnt_shift  = CNT_W'({cnt_fld_q, nib});
    assign cmd_shift  = CMD_W'({cmd_fld_q, nib});
    assign addr_shift = ADDR_W'({addr_fld_q, nib});
    assign data_shift = DATA_W'({data_fld_q, nib});

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0]    tmr_q, tmr_d;
`endif

    always_comb begin
        state_d       = state_q;
        nib_cnt_d     = nib_cnt_q;
        cnt_fld_d     = cnt_fld_q;
        cmd_fld_d     = cmd_fld_q;
        addr_fld_d    = addr_fld_q;
        data_fld_d    = data_fld_q;
        words_left_d  = words_left_q;
        hdr_valid_d   = 1'b0;
        out_command_d = out_command_q;
        out_address_d = out_address_q;
        out_count_d   = out_count_q;
        data_valid_d  = data_valid_q;
        out_data_d    = out_data_q;
        err_pulse_d   = 1'b0;
        err_code_d    = err_code_q;

        // Acceptance frees the output slot; a word completing in this same
        // cycle re-fills it below.
        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (byte_available) begin
            if (byte_in == ASCII_L) begin
                // Start (or restart) a frame; a pending data word survives.
                state_d    = ST_CNT;
                nib_cnt_d  = '0;
                cnt_fld_d  = '0;
                cmd_fld_d  = '0;
                addr_fld_d = '0;
                data_fld_d = '0;
            end else if (state_q != ST_IDLE) begin
                if (!is_hex) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_CHAR;
                    state_d     = ST_IDLE;
                    nib_cnt_d   = '0;
                end else begin
                    nib_cnt_d = nib_cnt_q + NIB_W'(1);
                    case (state_q)
                        ST_CNT: begin
                            cnt_fld_d = cnt_shift;
                            if (nib_cnt_q == CNT_LAST) begin
                                state_d   = ST_CMD;
                                nib_cnt_d = '0;
                            end
                        end
                        ST_CMD: begin
                            cmd_fld_d = cmd_shift;
                            if (nib_cnt_q == CMD_LAST) begin
                                state_d   = ST_ADDR;
                                nib_cnt_d = '0;
                            end
                        end
                        ST_ADDR: begin
                            addr_fld_d = addr_shift;
                            if (nib_cnt_q == ADDR_LAST) begin
                                state_d       = ST_DATA;
                                nib_cnt_d     = '0;
                                hdr_valid_d   = 1'b1;
                                out_command_d = cmd_fld_q;
                                out_address_d = addr_shift;
                                out_count_d   = cnt_fld_q;
                                words_left_d  = cnt_fld_q;
                            end
                        end
                        ST_DATA: begin
                            data_fld_d = data_shift;
                            if (nib_cnt_q == DATA_LAST) begin
                                nib_cnt_d = '0;
                                if (data_valid_q && !data_ready) begin
                                    // Slot still occupied: drop new word.
                                    err_pulse_d = 1'b1;
                                    err_code_d  = ERR_OVF;
                                    state_d     = ST_IDLE;
                                end else begin
                                    data_valid_d = 1'b1;
                                    out_data_d   = data_shift;
                                    if (words_left_q == '0) begin
                                        state_d = ST_IDLE;
                                    end else begin
                                        words_left_d = words_left_q - CNT_W'(1);
                                    end
                                end
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        end

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        // The timer is reloaded by any byte, so it is always fresh when a
        // frame starts. It expires on the cycle it would reach zero.
        tmr_d = tmr_q;
        if (byte_available) begin
            tmr_d = TMR_W'(TIMEOUT_CYC);
        end else if (state_q != ST_IDLE && tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q == TMR_W'(1)) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_TMO;
                state_d     = ST_IDLE;
                nib_cnt_d   = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            nib_cnt_q     <= '0;
            cnt_fld_q     <= '0;
            cmd_fld_q     <= '0;
            addr_fld_q    <= '0;
            data_fld_q    <= '0;
            words_left_q  <= '0;
            hdr_valid_q   <= 1'b0;
            out_command_q <= '0;
            out_address_q <= '0;
            out_count_q   <= '0;
            data_valid_q  <= 1'b0;
            out_data_q    <= '0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            nib_cnt_q     <= nib_cnt_d;
            cnt_fld_q     <= cnt_fld_d;
            cmd_fld_q     <= cmd_fld_d;
            addr_fld_q    <= addr_fld_d;
            data_fld_q    <= data_fld_d;
            words_left_q  <= words_left_d;
            hdr_valid_q   <= hdr_valid_d;
            out_command_q <= out_command_d;
            out_address_q <= out_address_d;
            out_count_q   <= out_count_d;
            data_valid_q  <= data_valid_d;
            out_data_q    <= out_data_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
        end
    end

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    assign hdr_valid   = hdr_valid_q;
    assign out_command = out_command_q;
    assign out_address = out_address_q;
    assign out_count   = out_count_q;
    assign data_valid  = data_valid_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;

endmodule : uart_frame_parser
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_parser
//  Description : Self-checking bench for uart_frame_parser. Stimulus pushes
//                expected headers, data words and error codes into queues;
//                a monitor on the falling clock edge pops and compares them
//                whenever the DUT presents the matching output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_frame_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_available = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        data_ready = 1'b0;
    logic        hdr_valid;
    logic [31:0] out_command;
    logic [31:0] out_address;
    logic [7:0]  out_count;
    logic        data_valid;
    logic [31:0] out_data;
    logic        busy;
    logic        err_pulse;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .CMD_W       (32),
        .ADDR_W      (32),
        .DATA_W      (32),
        .CNT_W       (8),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_available (byte_available),
        .byte_in        (byte_in),
        .hdr_valid      (hdr_valid),
        .out_command    (out_command),
        .out_address    (out_address),
        .out_count      (out_count),
        .data_valid     (data_valid),
        .out_data       (out_data),
        .data_ready     (data_ready),
        .busy           (busy),
        .err_pulse      (err_pulse),
        .err_code       (err_code)
    );

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] addr;
        logic [7:0]  cnt;
    } hdr_t;

    hdr_t        hdr_q[$];
    logic [31:0] data_q[$];
    logic [1:0]  err_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        n_total++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from input changes.
    // ------------------------------------------------------------------
    logic        prev_dv;
    logic        prev_acc;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (!rst) begin
            prev_dv  = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (hdr_valid) begin
                if (hdr_q.size() == 0) begin
                    report_fail("hdr_unexpected");
                end else begin
                    hdr_t h;
                    h = hdr_q.pop_front();
                    check("hdr_cmd",  64'(out_command), 64'(h.cmd));
                    check("hdr_addr", 64'(out_address), 64'(h.addr));
                    check("hdr_cnt",  64'(out_count),   64'(h.cnt));
                end
            end
            if (err_pulse) begin
                if (err_q.size() == 0) begin
                    report_fail("err_unexpected");
                end else begin
                    logic [1:0] e;
                    e = err_q.pop_front();
                    check("err_code", 64'(err_code), 64'(e));
                end
            end
            // A held word must neither vanish nor change before acceptance.
            if (prev_dv && !prev_acc) begin
                check("data_held_valid", 64'(data_valid), 64'd1);
                if (data_valid) begin
                    check("data_held_stable", 64'(out_data), 64'(prev_data));
                end
            end
            if (data_valid && data_ready) begin
                if (data_q.size() == 0) begin
                    report_fail("data_unexpected");
                end else begin
                    logic [31:0] d;
                    d = data_q.pop_front();
                    check("data_word", 64'(out_data), 64'(d));
                end
            end
            prev_dv   = data_valid;
            prev_acc  = data_valid && data_ready;
            prev_data = out_data;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: called at posedge+1, return at posedge+1.
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        byte_available = 1'b1;
        byte_in        = b;
        @(posedge clk);
        #1;
        byte_available = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_hdr(input logic [31:0] c, input logic [31:0] a, input logic [7:0] n);
        hdr_t h;
        h.cmd  = c;
        h.addr = a;
        h.cnt  = n;
        hdr_q.push_back(h);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_hdr_valid",  64'(hdr_valid),   64'd0);
        check("rst_command",    64'(out_command), 64'd0);
        check("rst_data_valid", 64'(data_valid),  64'd0);
        check("rst_busy",       64'(busy),        64'd0);
        check("rst_err_code",   64'(err_code),    64'd0);
        rst = 1'b1;
        idle(2);

        // ---------------- single-word frame ----------------
        data_ready = 1'b1;
        push_hdr(32'h00000001, 32'h40000000, 8'h00);
        data_q.push_back(32'hDEADBEEF);
        send_byte("L");
        check("busy_after_L", 64'(busy), 64'd1);
        send_str("0000000001");
        send_str("40000000");
        check("busy_in_data", 64'(busy), 64'd1);
        send_str("DEADBEEF");
        check("busy_after_single", 64'(busy), 64'd0);
        idle(3);

        // ---------------- burst, lowercase ----------------
        push_hdr(32'h00000002, 32'h00000010, 8'h02);
        data_q.push_back(32'h0000000A);
        data_q.push_back(32'h0000000B);
        data_q.push_back(32'h0000000C);
        send_str("L0200000002");
        send_str("00000010");
        send_str("0000000a");
        send_str("0000000b");
        check("busy_mid_burst", 64'(busy), 64'd1);
        send_str("0000000c");
        check("busy_after_burst", 64'(busy), 64'd0);
        idle(3);

        // ---------------- backpressure / overflow ----------------
        data_ready = 1'b0;
        push_hdr(32'h00000003, 32'h00000020, 8'h01);
        send_str("L0100000003");
        send_str("00000020");
        send_str("11111111");
        check("bp_valid_first", 64'(data_valid), 64'd1);
        check("bp_data_first",  64'(out_data),   64'h11111111);
        err_q.push_back(2'd2);
        send_str("22222222");
        check("ovf_code",       64'(err_code),   64'd2);
        check("ovf_busy",       64'(busy),       64'd0);
        check("ovf_held_valid", 64'(data_valid), 64'd1);
        check("ovf_held_data",  64'(out_data),   64'h11111111);
        idle(3);
        data_q.push_back(32'h11111111);
        data_ready = 1'b1;
        idle(2);
        check("bp_released", 64'(data_valid), 64'd0);

        // ---------------- bad character ----------------
        err_q.push_back(2'd1);
        send_str("L0G");
        check("bad_code", 64'(err_code), 64'd1);
        check("bad_busy", 64'(busy),     64'd0);
        idle(2);

        // ---------------- resync on 'L' ----------------
        push_hdr(32'h00000004, 32'h00000030, 8'h00);
        data_q.push_back(32'hCAFEF00D);
        send_str("L00001");
        send_str("L0000000004");
        send_str("00000030");
        send_str("CAFEF00D");
        check("resync_busy",     64'(busy),     64'd0);
        check("resync_err_held", 64'(err_code), 64'd1);
        idle(3);

        // ---------------- reset mid-frame ----------------
        push_hdr(32'h00000005, 32'h00000050, 8'h00);
        send_str("L0000000005");
        send_str("00000050");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mrst_busy",       64'(busy),        64'd0);
        check("mrst_command",    64'(out_command), 64'd0);
        check("mrst_address",    64'(out_address), 64'd0);
        check("mrst_count",      64'(out_count),   64'd0);
        check("mrst_data_valid", 64'(data_valid),  64'd0);
        check("mrst_err_code",   64'(err_code),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        push_hdr(32'h00000006, 32'h00000060, 8'h00);
        data_q.push_back(32'h12345678);
        send_str("L0000000006");
        send_str("00000060");
        send_str("12345678");
        check("post_rst_busy", 64'(busy), 64'd0);
        idle(3);

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        // ---------------- inter-byte timeout ----------------
        begin
            int k;
            k = 0;
            err_q.push_back(2'd3);
            send_str("L00");
            for (int i = 1; i <= 60; i++) begin
                @(posedge clk);
                #1;
                if (err_pulse && k == 0) begin
                    k = i;
                end
            end
            check("tmo_latency", 64'(k),        64'd50);
            check("tmo_code",    64'(err_code), 64'd3);
            check("tmo_busy",    64'(busy),     64'd0);
        end
`endif

        // ---------------- all expectations consumed ----------------
        idle(3);
        check("hdr_queue_empty",  64'(hdr_q.size()),  64'd0);
        check("data_queue_empty", 64'(data_q.size()), 64'd0);
        check("err_queue_empty",  64'(err_q.size()),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_frame_parser
`default_nettype wire
